instr_ram_arbiter: RTL

Two-port arbiter in front of `instr_ram_wrap`. It shares the single instruction RAM/boot-ROM port between the core instruction-fetch port (port 0, read-only) and the bus/loader port (port 1, read/write). The bus port has fixed priority, backed by a starvation counter that guarantees the fetch port a grant. The arbiter tracks the one-cycle read latency, routing `rdata` and `rvalid` to the port granted in the previous cycle.

---
 rtl/instr_ram_arb_pkg.sv | 13 +
 rtl/arb_starve_cnt.sv | 32 +++
 rtl/instr_ram_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/instr_ram_arb_pkg.sv
// Shared types for the instruction RAM arbiter.
// Response tracking enum and starvation counter width.
package instr_ram_arb_pkg;

    localparam int ARB_WAIT_W = 8;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_P0,
        RESP_P1
    } resp_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port was denied.
// Flags starvation once the count reaches MAX_WAIT.
module arb_starve_cnt
    import instr_ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starve
);

    localparam logic [ARB_WAIT_W-1:0] LP_MAX = ARB_WAIT_W'(MAX_WAIT);

    logic [ARB_WAIT_W-1:0] r_cnt;

    // Clear wins over increment when the fetch port is served
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != LP_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starve = (r_cnt == LP_MAX);

endmodule

// File: rtl/instr_ram_arbiter.sv
// Shares one instruction RAM/boot-ROM port between fetch (p0) and bus (p1).
// Bus has priority; a starvation counter guarantees fetch progress.
module instr_ram_arbiter
    import instr_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p0_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    p1_rom_wr_err_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    logic  w_starve;
    logic  w_gnt0;
    logic  w_gnt1;
    logic  w_rom_wr;
    resp_e r_resp;
    resp_e w_resp_nxt;
    logic  r_rom_err;
    logic  w_p0_rvalid;
    logic  w_p1_rvalid;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (p0_req_i),
        .i_gnt    (w_gnt0),
        .o_starve (w_starve)
    );

    assign w_gnt0   = rst_n && p0_req_i && (!p1_req_i || w_starve);
    assign w_gnt1   = rst_n && p1_req_i && !w_gnt0;
    assign w_rom_wr = w_gnt1 && p1_we_i && p1_addr_i[ADDR_WIDTH-1];

    assign p0_gnt_o = w_gnt0;
    assign p1_gnt_o = w_gnt1;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        if (w_gnt0) begin
            mem_en_o   = 1'b1;
            mem_addr_o = p0_addr_i;
            mem_be_o   = '1;
        end else if (w_gnt1) begin
            // Boot ROM is read-only: answer the write but keep memory idle
            mem_en_o    = !w_rom_wr;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
            mem_we_o    = p1_we_i && !w_rom_wr;
            mem_be_o    = p1_be_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp    <= RESP_NONE;
            r_rom_err <= 1'b0;
        end else begin
            r_resp    <= w_resp_nxt;
            r_rom_err <= w_rom_wr;
        end
    end

    always_comb begin
        w_resp_nxt = RESP_NONE;
        if (w_gnt0) begin
            w_resp_nxt = RESP_P0;
        end else if (w_gnt1) begin
            w_resp_nxt = RESP_P1;
        end
    end

    // Gating with rst_n drops a response still in flight when reset hits
    always_comb begin
        w_p0_rvalid     = rst_n && (r_resp == RESP_P0);
        w_p1_rvalid     = rst_n && (r_resp == RESP_P1);
        p0_rvalid_o     = w_p0_rvalid;
        p1_rvalid_o     = w_p1_rvalid;
        p1_rom_wr_err_o = rst_n && r_rom_err;
        p0_rdata_o      = w_p0_rvalid ? mem_rdata_i : '0;
        p1_rdata_o      = w_p1_rvalid ? mem_rdata_i : '0;
    end

endmodule
